aurora_rx_lock_ctrl: RTL and testbench
======================================

# aurora_rx_lock_ctrl

Block-lock controller for one Aurora 64b/66b receive lane. It watches the 2-bit sync headers from the lane gearbox and declares block lock after a run of legal headers. While hunting, it steps the gearbox alignment with single-cycle slip pulses and escalates to a SERDES bitslip after a full 66-position sweep. It sits beside the gearbox in `aurora_rx_lane`, runs on the lane's `clk_rx_i` domain, and drives the lane's lock and slip status.

## Interface
Parameters:
- `LOCK_GOOD_CNT`, 64: consecutive legal headers required to declare lock.
- `WINDOW`, 64: number of valid headers per monitoring window while locked.
- `UNLOCK_BAD_CNT`, 16: illegal headers within one window that drop lock.
- `SLIP_WAIT`, 32: cycles headers are ignored after each slip, for gearbox settling.
- `SLIPS_PER_SWEEP`, 66: gearbox slips per full sweep; each full sweep triggers one SERDES bitslip.
- `FAIL_SWEEPS`, 2: full sweeps without lock before `sweep_fail_o` is set.

Ports:
- `clk_rx_i` in 1: lane parallel clock; the only clock.
- `rst_n_i` in 1: reset, asynchronous and active-low.
- `hdr_i` in 2: sync header from the gearbox. `2'b01` and `2'b10` are legal; `2'b00` and `2'b11` are illegal.
- `hdr_valid_i` in 1: `hdr_i` qualifier. The gearbox drops it periodically.
- `gbox_slip_o` out 1: one-cycle pulse; shift gearbox alignment by one bit.
- `serdes_slip_o` out 1: one-cycle pulse; SERDES bitslip request.
- `locked_o` out 1: block lock.
- `sweep_fail_o` out 1: sticky; `FAIL_SWEEPS` full sweeps completed without lock.
- `slip_cnt_o` out 7: gearbox slips within the current sweep.
- `state_o` out 2: FSM state. HUNT=0, SLIP=1, WAIT=2, LOCKED=3.

## Operation
- FSM states: HUNT, SLIP, WAIT, LOCKED. Reset state is HUNT.
- Headers are evaluated only in cycles where `hdr_valid_i`=1. Cycles with `hdr_valid_i`=0 leave `good_cnt`, `win_cnt` and `bad_cnt` unchanged.
- HUNT:
  - Legal header: increment `good_cnt`. When the increment reaches `LOCK_GOOD_CNT`, go to LOCKED.
  - Illegal header: clear `good_cnt` and go to SLIP.
- SLIP (exactly one cycle):
  - Assert `gbox_slip_o` and increment `slip_cnt`.
  - If the new `slip_cnt` equals `SLIPS_PER_SWEEP`: assert `serdes_slip_o` in the same cycle, clear `slip_cnt` to 0, and increment `sweep_cnt`.
  - If `sweep_cnt` reaches `FAIL_SWEEPS`: set `sweep_fail_o`. `sweep_cnt` saturates at that value. Hunting continues.
  - Go to WAIT.
- WAIT:
  - `wait_cnt` counts every clock regardless of `hdr_valid_i`; all headers are ignored.
  - After `SLIP_WAIT` cycles, go to HUNT with `good_cnt`=0.
- Entry to LOCKED: clear `slip_cnt`, `sweep_cnt`, `win_cnt` and `bad_cnt`. `sweep_fail_o` is retained.
- LOCKED:
  - Each valid header increments `win_cnt`. Each illegal header also increments `bad_cnt`.
  - When `bad_cnt` reaches `UNLOCK_BAD_CNT`: go to HUNT and clear `good_cnt`, `win_cnt` and `bad_cnt`. Slip counters start from 0.
  - When `win_cnt` reaches `WINDOW` without the unlock threshold: clear `win_cnt` and `bad_cnt`, stay LOCKED.
  - If the window closes and the threshold is hit on the same header, unlock wins.
- Counter widths are `$clog2(max+1)`, wide enough to hold the terminal value. No counter wraps except `slip_cnt` at the sweep boundary.
- `sweep_fail_o` clears only on reset.

## Timing
- All outputs are registered.
- Reset value of every output is 0; `state_o`=0 (HUNT).
- Assertion of `rst_n_i` clears all state and outputs immediately, asynchronously, from any state, including mid-pulse.
- `locked_o` rises on the clock edge after the `LOCK_GOOD_CNT`-th legal header is sampled.
- `locked_o` falls on the edge after the `UNLOCK_BAD_CNT`-th illegal header in a window is sampled.
- `gbox_slip_o` is high for exactly one cycle, starting the cycle after the offending header is sampled.
- Minimum slip-to-slip spacing is `SLIP_WAIT`+2 cycles (34 with defaults): SLIP + WAIT + 1 HUNT cycle.
- `serdes_slip_o` is coincident with the 66th `gbox_slip_o` pulse of a sweep. It never asserts without `gbox_slip_o`.
- `slip_cnt_o` updates on the same edge that `gbox_slip_o` rises: 1 on the first slip, then 0 on the 66th.

## Test plan
- Reset release, then 64 headers of `2'b01` with `hdr_valid_i`=1 -> `locked_o`=1 one cycle after the 64th header; `gbox_slip_o` never pulses; `state_o`=3.
- Illegal header `2'b11` as the 10th header in HUNT -> one `gbox_slip_o` pulse; 32 ignored cycles follow; lock arrives 64 legal headers after WAIT exits; `slip_cnt_o`=1 until lock, then 0.
- Constant `2'b00` headers -> slips every 34 cycles.
  - 66th slip: `serdes_slip_o` coincident and `slip_cnt_o` returns to 0.
  - After 132 slips: `sweep_fail_o`=1, held until reset.
- Locked lane with 15 illegal headers in one 64-header window -> stays locked; next window is clean.
- Locked lane with 16 illegal headers in one window -> `locked_o`=0 the cycle after the 16th; `state_o`=0.
- `hdr_valid_i` low 1 cycle in every 33 during HUNT -> lock still requires exactly 64 valid legal headers; `rst_n_i` pulsed mid-WAIT -> all outputs 0 immediately, HUNT resumes.

Source files
------------

// File: rtl/aurora_rx_lock_ctrl_if.sv
// aurora_rx_lock_ctrl_if: sync-header input and lock/slip status bundle for one Aurora rx lane
interface aurora_rx_lock_ctrl_if;
    logic [1:0] hdr_i;
    logic       hdr_valid_i;
    logic       gbox_slip_o;
    logic       serdes_slip_o;
    logic       locked_o;
    logic       sweep_fail_o;
    logic [6:0] slip_cnt_o;
    logic [1:0] state_o;
    modport master (
        output hdr_i, hdr_valid_i,
        input  gbox_slip_o, serdes_slip_o, locked_o, sweep_fail_o, slip_cnt_o, state_o
    );
    modport slave (
        input  hdr_i, hdr_valid_i,
        output gbox_slip_o, serdes_slip_o, locked_o, sweep_fail_o, slip_cnt_o, state_o
    );
endinterface

// File: rtl/aurora_rx_lock_ctrl.sv
// aurora_rx_lock_ctrl: 64b/66b block-lock FSM with gearbox slip sweep and SERDES bitslip escalation
module aurora_rx_lock_ctrl #(
    parameter int LOCK_GOOD_CNT   = 64,
    parameter int WINDOW          = 64,
    parameter int UNLOCK_BAD_CNT  = 16,
    parameter int SLIP_WAIT       = 32,
    parameter int SLIPS_PER_SWEEP = 66,
    parameter int FAIL_SWEEPS     = 2
) (
    input logic                  clk_rx_i,
    input logic                  rst_n_i,
    aurora_rx_lock_ctrl_if.slave lane
);
    localparam int GW = $clog2(LOCK_GOOD_CNT + 1);
    localparam int NW = $clog2(WINDOW + 1);
    localparam int BW = $clog2(UNLOCK_BAD_CNT + 1);
    localparam int TW = $clog2(SLIP_WAIT + 1);
    localparam int SW = $clog2(FAIL_SWEEPS + 1);
    localparam logic [GW-1:0] GOOD_MAX  = GW'(LOCK_GOOD_CNT);
    localparam logic [NW-1:0] WIN_MAX   = NW'(WINDOW);
    localparam logic [BW-1:0] BAD_MAX   = BW'(UNLOCK_BAD_CNT);
    localparam logic [TW-1:0] WAIT_LAST = TW'(SLIP_WAIT - 1);
    localparam logic [6:0]    SLIP_MAX  = 7'(SLIPS_PER_SWEEP);
    localparam logic [SW-1:0] SWEEP_MAX = SW'(FAIL_SWEEPS);

    typedef enum logic [1:0] {HUNT = 2'd0, SLIP = 2'd1, WAIT = 2'd2, LOCKED = 2'd3} state_t;

    state_t        state, state_nx;
    logic [GW-1:0] good, good_nx, good_inc;
    logic [NW-1:0] win, win_nx, win_inc;
    logic [BW-1:0] bad, bad_nx, bad_new;
    logic [TW-1:0] wcnt, wcnt_nx;
    logic [6:0]    slip, slip_nx, slip_inc;
    logic [SW-1:0] sweep, sweep_nx;
    logic          fail, fail_nx, gslip, gslip_nx, sslip, sslip_nx, locked, locked_nx;
    logic          legal, wrap;

    assign legal    = ^lane.hdr_i;
    assign good_inc = good + 1'b1;
    assign win_inc  = win + 1'b1;
    assign bad_new  = legal ? bad : bad + 1'b1;
    assign slip_inc = slip + 1'b1;
    assign wrap     = slip_inc == SLIP_MAX;

    // Slip side effects are registered on entry to SLIP so the pulse and slip_cnt_o share an edge
    always_comb begin
        state_nx = state;
        good_nx  = good;
        win_nx   = win;
        bad_nx   = bad;
        wcnt_nx  = wcnt;
        slip_nx  = slip;
        sweep_nx = sweep;
        fail_nx  = fail;
        gslip_nx = 1'b0;
        sslip_nx = 1'b0;
        case (state)
            HUNT: begin
                if (lane.hdr_valid_i && legal) begin
                    good_nx = good_inc;
                    if (good_inc == GOOD_MAX) begin
                        state_nx = LOCKED;
                        good_nx  = '0;
                        slip_nx  = '0;
                        sweep_nx = '0;
                        win_nx   = '0;
                        bad_nx   = '0;
                    end
                end else if (lane.hdr_valid_i) begin
                    state_nx = SLIP;
                    good_nx  = '0;
                    gslip_nx = 1'b1;
                    sslip_nx = wrap;
                    slip_nx  = wrap ? '0 : slip_inc;
                    sweep_nx = (wrap && sweep != SWEEP_MAX) ? sweep + 1'b1 : sweep;
                    fail_nx  = fail | (sweep_nx == SWEEP_MAX);
                end
            end
            SLIP: begin
                state_nx = WAIT;
                wcnt_nx  = '0;
            end
            WAIT: begin
                wcnt_nx  = wcnt + 1'b1;
                state_nx = wcnt == WAIT_LAST ? HUNT : WAIT;
                good_nx  = '0;
            end
            LOCKED: begin
                if (lane.hdr_valid_i) begin
                    win_nx = win_inc;
                    bad_nx = bad_new;
                    if (bad_new == BAD_MAX) begin
                        state_nx = HUNT;
                        good_nx  = '0;
                        win_nx   = '0;
                        bad_nx   = '0;
                    end else if (win_inc == WIN_MAX) begin
                        win_nx = '0;
                        bad_nx = '0;
                    end
                end
            end
        endcase
        locked_nx = state_nx == LOCKED;
    end

    always_ff @(posedge clk_rx_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= HUNT;
            good   <= '0;
            win    <= '0;
            bad    <= '0;
            wcnt   <= '0;
            slip   <= '0;
            sweep  <= '0;
            fail   <= 1'b0;
            gslip  <= 1'b0;
            sslip  <= 1'b0;
            locked <= 1'b0;
        end else begin
            state  <= state_nx;
            good   <= good_nx;
            win    <= win_nx;
            bad    <= bad_nx;
            wcnt   <= wcnt_nx;
            slip   <= slip_nx;
            sweep  <= sweep_nx;
            fail   <= fail_nx;
            gslip  <= gslip_nx;
            sslip  <= sslip_nx;
            locked <= locked_nx;
        end
    end

    assign lane.gbox_slip_o   = gslip;
    assign lane.serdes_slip_o = sslip;
    assign lane.locked_o      = locked;
    assign lane.sweep_fail_o  = fail;
    assign lane.slip_cnt_o    = slip;
    assign lane.state_o       = state;
endmodule

// File: tb/tb_aurora_rx_lock_ctrl.sv
// tb_aurora_rx_lock_ctrl: randomized lock/slip scenarios checked against a cycle-level behavioural model
module tb_aurora_rx_lock_ctrl;
    localparam int GOOD = 64, WIN = 64, BAD = 16, SWAIT = 32, SPS = 66, FS = 2;

    logic clk_rx_i = 1'b0;
    logic rst_n_i  = 1'b0;
    always #5 clk_rx_i = ~clk_rx_i;

    aurora_rx_lock_ctrl_if lane();
    aurora_rx_lock_ctrl dut (.clk_rx_i(clk_rx_i), .rst_n_i(rst_n_i), .lane(lane));

    int total = 0, passed = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: settle counts the ignored cycles (one SLIP + SLIP_WAIT) left after a slip
    bit m_locked = 0, m_fail = 0, m_gslip = 0, m_sslip = 0;
    int m_good = 0, m_win = 0, m_bad = 0, m_settle = 0, m_slips = 0, m_sweeps = 0;

    function automatic int m_state();
        return m_settle == SWAIT + 1 ? 1 : m_settle > 0 ? 2 : m_locked ? 3 : 0;
    endfunction

    initial forever begin
        @(posedge clk_rx_i or negedge rst_n_i);
        if (!rst_n_i) begin
            m_locked = 0; m_fail = 0; m_gslip = 0; m_sslip = 0;
            m_good = 0; m_win = 0; m_bad = 0; m_settle = 0; m_slips = 0; m_sweeps = 0;
        end else begin
            bit legal;
            legal = lane.hdr_i == 2'b01 || lane.hdr_i == 2'b10;
            m_gslip = 0;
            m_sslip = 0;
            if (m_settle > 0) m_settle--;
            else if (lane.hdr_valid_i) begin
                if (m_locked) begin
                    m_win++;
                    if (!legal) m_bad++;
                    if (m_bad == BAD) begin m_locked = 0; m_good = 0; m_win = 0; m_bad = 0; end
                    else if (m_win == WIN) begin m_win = 0; m_bad = 0; end
                end else if (legal) begin
                    m_good++;
                    if (m_good == GOOD) begin
                        m_locked = 1; m_good = 0; m_slips = 0; m_sweeps = 0; m_win = 0; m_bad = 0;
                    end
                end else begin
                    m_good = 0;
                    m_settle = SWAIT + 1;
                    m_gslip = 1;
                    m_slips++;
                    if (m_slips == SPS) begin
                        m_slips = 0;
                        m_sslip = 1;
                        if (m_sweeps < FS) m_sweeps++;
                        if (m_sweeps == FS) m_fail = 1;
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk_rx_i);
        chk("gbox_slip", lane.gbox_slip_o, m_gslip);
        chk("serdes_slip", lane.serdes_slip_o, m_sslip);
        chk("locked", lane.locked_o, m_locked);
        chk("sweep_fail", lane.sweep_fail_o, m_fail);
        chk("slip_cnt", lane.slip_cnt_o, m_slips);
        chk("state", lane.state_o, m_state());
    end

    // Pulse bookkeeping, sampled just after the active edge
    int cyc_n = 0, n_g = 0, n_s = 0, last_g = -1, gap = 0;
    initial forever begin
        @(posedge clk_rx_i or negedge rst_n_i);
        #1;
        cyc_n++;
        if (!rst_n_i) begin n_g = 0; n_s = 0; last_g = -1; gap = 0; end
        else if (lane.gbox_slip_o) begin
            n_g++;
            if (lane.serdes_slip_o) n_s++;
            if (last_g >= 0) gap = cyc_n - last_g;
            last_g = cyc_n;
        end
    end

    function automatic logic [1:0] lh();
        return $urandom_range(0, 1) ? 2'b01 : 2'b10;
    endfunction
    function automatic logic [1:0] ih();
        return $urandom_range(0, 1) ? 2'b00 : 2'b11;
    endfunction

    task automatic cyc(input logic [1:0] h, input logic v);
        lane.hdr_i = h;
        lane.hdr_valid_i = v;
        @(negedge clk_rx_i);
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        lane.hdr_i = 2'b00;
        lane.hdr_valid_i = 1'b0;
        repeat (3) @(negedge clk_rx_i);
        rst_n_i = 1'b1;
    endtask

    task automatic async_rst(input string tag);
        #2 rst_n_i = 1'b0;
        #1;
        chk({tag, "_gbox"}, lane.gbox_slip_o, 0);
        chk({tag, "_serdes"}, lane.serdes_slip_o, 0);
        chk({tag, "_locked"}, lane.locked_o, 0);
        chk({tag, "_fail"}, lane.sweep_fail_o, 0);
        chk({tag, "_slipcnt"}, lane.slip_cnt_o, 0);
        chk({tag, "_state"}, lane.state_o, 0);
        @(negedge clk_rx_i);
        rst_n_i = 1'b1;
    endtask

    task automatic lock_legal(input string tag);
        repeat (GOOD - 1) cyc(lh(), 1'b1);
        chk({tag, "_pre_lock"}, lane.locked_o, 0);
        cyc(lh(), 1'b1);
        chk({tag, "_lock"}, lane.locked_o, 1);
        chk({tag, "_lock_state"}, lane.state_o, 3);
    endtask

    initial begin
        bit seen66;
        bit isbad [64];
        int nv, k, pe;
        lane.hdr_i = 2'b00;
        lane.hdr_valid_i = 1'b0;
        repeat (3) @(negedge clk_rx_i);
        chk("rst_locked", lane.locked_o, 0);
        chk("rst_state", lane.state_o, 0);
        chk("rst_slipcnt", lane.slip_cnt_o, 0);
        chk("rst_gbox", lane.gbox_slip_o, 0);
        rst_n_i = 1'b1;
        repeat (GOOD - 1) cyc(2'b01, 1'b1);
        chk("t1_pre_lock", lane.locked_o, 0);
        cyc(2'b01, 1'b1);
        chk("t1_lock", lane.locked_o, 1);
        chk("t1_state", lane.state_o, 3);
        chk("t1_no_slip", n_g, 0);

        do_reset();
        repeat (9) cyc(lh(), 1'b1);
        cyc(2'b11, 1'b1);
        chk("t2_gbox", lane.gbox_slip_o, 1);
        chk("t2_slipcnt", lane.slip_cnt_o, 1);
        chk("t2_state_slip", lane.state_o, 1);
        repeat (SWAIT) cyc(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        chk("t2_state_wait", lane.state_o, 2);
        cyc(ih(), 1'b1);
        chk("t2_state_hunt", lane.state_o, 0);
        chk("t2_one_slip", n_g, 1);
        lock_legal("t2");
        chk("t2_slipcnt_lock", lane.slip_cnt_o, 0);

        do_reset();
        seen66 = 0;
        for (int i = 0; i < 5000 && n_g < 2 * SPS; i++) begin
            cyc(2'b00, 1'b1);
            if (n_g == SPS && !seen66) begin
                seen66 = 1;
                chk("t3_serdes_66", lane.serdes_slip_o, 1);
                chk("t3_slipcnt_wrap", lane.slip_cnt_o, 0);
                chk("t3_fail_early", lane.sweep_fail_o, 0);
            end
        end
        chk("t3_slips", n_g, 2 * SPS);
        chk("t3_serdes_cnt", n_s, 2);
        chk("t3_gap", gap, SWAIT + 2);
        chk("t3_fail", lane.sweep_fail_o, 1);
        repeat (SWAIT + 1) cyc(2'b00, 1'b1);
        lock_legal("t3");
        chk("t3_fail_held", lane.sweep_fail_o, 1);
        async_rst("t3_rst");

        do_reset();
        lock_legal("t4");
        foreach (isbad[i]) isbad[i] = 0;
        for (int i = 0; i < BAD - 1; i++) isbad[i * 4 + $urandom_range(0, 3)] = 1;
        for (int j = 0; j < WIN; j++) begin
            if ($urandom_range(0, 4) == 0) cyc(ih(), 1'b0);
            cyc(isbad[j] ? ih() : lh(), 1'b1);
        end
        chk("t4_15bad_locked", lane.locked_o, 1);
        cyc(ih(), 1'b1);
        for (int j = 1; j < WIN; j++) begin
            if ($urandom_range(0, 4) == 0) cyc(ih(), 1'b0);
            cyc(lh(), 1'b1);
        end
        chk("t4_clean_locked", lane.locked_o, 1);
        repeat (24) cyc(lh(), 1'b1);
        repeat (BAD - 1) cyc(ih(), 1'b1);
        chk("t4_15_of_16", lane.locked_o, 1);
        cyc(ih(), 1'b1);
        chk("t4_unlock", lane.locked_o, 0);
        chk("t4_unlock_state", lane.state_o, 0);

        do_reset();
        nv = 0;
        k = 0;
        while (nv < GOOD) begin
            if (k % 33 == 32) cyc(2'b11, 1'b0);
            else begin
                cyc(lh(), 1'b1);
                nv++;
                if (nv == GOOD - 1) chk("t5_pre_lock", lane.locked_o, 0);
            end
            k++;
        end
        chk("t5_lock", lane.locked_o, 1);
        do_reset();
        repeat (5) cyc(lh(), 1'b1);
        cyc(2'b00, 1'b1);
        repeat (10) cyc(ih(), 1'b1);
        chk("t5_mid_wait", lane.state_o, 2);
        async_rst("t5_rst");
        chk("t5_hunt", lane.state_o, 0);
        lock_legal("t5");

        do_reset();
        pe = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) pe = $urandom_range(0, 3) * 10 + (i % 400 == 0 ? 0 : 2);
            cyc($urandom_range(0, 99) < pe ? ih() : lh(), 1'($urandom_range(0, 9) != 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
